can_crc_sequencer: RTL and testbench

Frame-field tracker and controller for the 15-bit CAN CRC LFSR on the receive path. It consumes the de-stuffed serial bitstream and walks the CAN 2.0A/2.0B frame fields from SOF through the CRC field. It gates the CRC unit's `crc_en` over SOF..end-of-data, and snapshots the computed CRC at the start of the CRC field. It then compares the 15 received CRC bits against the snapshot and reports pass or fail. It sits between the bit de-stuffer and the CRC LFSR.

---
 rtl/can_crc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_can_crc_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_crc_sequencer.sv
// CAN receive-path frame-field tracker: walks SOF..CRC, gates the CRC LFSR
// over SOF..end-of-data, and checks the 15 received CRC bits against a snapshot.
module can_crc_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bit_valid,
   input  logic        bit_in,
   input  logic        sof,
   input  logic        abort,
   input  logic [14:0] crc_in,
   output logic        crc_init,
   output logic        crc_en,
   output logic        crc_din,
   output logic        crc_field,
   output logic        ide,
   output logic        rtr,
   output logic [3:0]  dlc,
   output logic        done,
   output logic        crc_ok,
   output logic        crc_err
);

   typedef enum logic [3:0] {
      S_IDLE, S_ID_A, S_SRR_RTR, S_IDE, S_ID_B, S_RTR_B,
      S_R1, S_R0, S_DLC, S_DATA, S_CRC
   } state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [14:0] expected;
   logic        err;

   // Remote frames carry no data; DLC above 8 still means 8 bytes.
   function automatic logic [6:0] data_len(input logic is_rtr, input logic [3:0] d);
      if (is_rtr)
         data_len = 7'd0;
      else if (d[3])
         data_len = 7'd64;
      else
         data_len = {1'b0, d[2:0], 3'b000};
   endfunction

   logic [3:0]  dlc_shifted;
   logic [6:0]  len_now;
   logic        exp_bit;
   logic        mismatch;

   assign dlc_shifted = {dlc[2:0], bit_in};
   assign len_now     = data_len(rtr, dlc_shifted);
   // The first CRC bit compares straight against the live CRC unit value.
   assign exp_bit     = (cnt == 6'd14) ? crc_in[14] : expected[14];
   assign mismatch    = bit_in ^ exp_bit;

   assign crc_init = rst_n & bit_valid & sof & ~abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= 6'd0;
         expected  <= 15'd0;
         err       <= 1'b0;
         crc_en    <= 1'b0;
         crc_din   <= 1'b0;
         crc_field <= 1'b0;
         ide       <= 1'b0;
         rtr       <= 1'b0;
         dlc       <= 4'd0;
         done      <= 1'b0;
         crc_ok    <= 1'b0;
         crc_err   <= 1'b0;
      end else begin
         done   <= 1'b0;
         crc_en <= 1'b0;
         if (abort) begin
            state     <= S_IDLE;
            crc_field <= 1'b0;
            err       <= 1'b0;
         end else if (bit_valid && sof) begin
            state     <= S_ID_A;
            cnt       <= 6'd10;
            crc_en    <= 1'b1;
            crc_din   <= bit_in;
            crc_field <= 1'b0;
            err       <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            ide       <= 1'b0;
            rtr       <= 1'b0;
            dlc       <= 4'd0;
         end else if (bit_valid && state != S_IDLE) begin
            cnt <= cnt - 6'd1;
            if (state != S_CRC) begin
               crc_en  <= 1'b1;
               crc_din <= bit_in;
            end
            case (state)
               S_ID_A:
                  if (cnt == 6'd0) state <= S_SRR_RTR;
               S_SRR_RTR: begin
                  rtr   <= bit_in;
                  state <= S_IDE;
               end
               S_IDE: begin
                  ide <= bit_in;
                  if (bit_in) begin
                     state <= S_ID_B;
                     cnt   <= 6'd17;
                  end else begin
                     state <= S_R0;
                  end
               end
               S_ID_B:
                  if (cnt == 6'd0) state <= S_RTR_B;
               S_RTR_B: begin
                  rtr   <= bit_in;
                  state <= S_R1;
               end
               S_R1:
                  state <= S_R0;
               S_R0: begin
                  state <= S_DLC;
                  cnt   <= 6'd3;
               end
               S_DLC: begin
                  dlc <= dlc_shifted;
                  if (cnt == 6'd0) begin
                     if (len_now == 7'd0) begin
                        state     <= S_CRC;
                        crc_field <= 1'b1;
                        cnt       <= 6'd14;
                     end else begin
                        state <= S_DATA;
                        cnt   <= len_now[5:0] - 6'd1;
                     end
                  end
               end
               S_DATA:
                  if (cnt == 6'd0) begin
                     state     <= S_CRC;
                     crc_field <= 1'b1;
                     cnt       <= 6'd14;
                  end
               S_CRC: begin
                  if (cnt == 6'd14)
                     expected <= {crc_in[13:0], 1'b0};
                  else
                     expected <= {expected[13:0], 1'b0};
                  if (cnt == 6'd0) begin
                     state     <= S_IDLE;
                     crc_field <= 1'b0;
                     done      <= 1'b1;
                     crc_ok    <= ~(err | mismatch);
                     crc_err   <= err | mismatch;
                     err       <= 1'b0;
                  end else begin
                     err <= err | mismatch;
                  end
               end
               default:
                  state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_can_crc_sequencer.sv
// Bench for can_crc_sequencer: builds CAN frames as bit lists, runs them through
// a behavioural CRC-15 unit, and checks gating, captured fields and the verdict.
module tb_can_crc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bit_valid = 1'b0;
   logic        bit_in = 1'b0;
   logic        sof = 1'b0;
   logic        abort = 1'b0;
   logic [14:0] crc_in;
   logic        crc_init, crc_en, crc_din, crc_field, ide, rtr, done, crc_ok, crc_err;
   logic [3:0]  dlc;

   int n_checks = 0;
   int n_fail   = 0;

   can_crc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
      .sof(sof), .abort(abort), .crc_in(crc_in), .crc_init(crc_init),
      .crc_en(crc_en), .crc_din(crc_din), .crc_field(crc_field), .ide(ide),
      .rtr(rtr), .dlc(dlc), .done(done), .crc_ok(crc_ok), .crc_err(crc_err)
   );

   always #5 clk = ~clk;

   // CRC-15 unit the sequencer drives (polynomial 0x4599, seed 0).
   logic [14:0] crc_reg;
   assign crc_in = crc_reg;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         crc_reg <= 15'd0;
      else if (crc_init)
         crc_reg <= 15'd0;
      else if (crc_en)
         crc_reg <= ({crc_reg[13:0], 1'b0}) ^ ((crc_din ^ crc_reg[14]) ? 15'h4599 : 15'h0);
   end

   // Monitor: running totals, snapshotted by each test.
   int en_total = 0, done_total = 0, init_total = 0, en_at_rise = -1;
   bit din_q[$];
   logic field_prev = 1'b0;
   always @(negedge clk) begin
      if (crc_en) begin
         en_total = en_total + 1;
         din_q.push_back(crc_din);
      end
      if (done) done_total = done_total + 1;
      if (crc_init) init_total = init_total + 1;
      if (crc_field && !field_prev) en_at_rise = en_total;
      field_prev = crc_field;
   end

   bit hdr[$];
   logic [14:0] frame_crc;

   // Pure bit-list CRC over the SOF..data bits, independent of DUT timing.
   task automatic compute_crc();
      logic [14:0] c;
      c = 15'd0;
      foreach (hdr[i]) begin
         logic nb;
         nb = hdr[i] ^ c[14];
         c = {c[13:0], 1'b0};
         if (nb) c = c ^ 15'h4599;
      end
      frame_crc = c;
   endtask

   task automatic build_frame(input bit x_ide, input bit x_rtr, input logic [3:0] x_dlc,
                              input logic [28:0] id);
      int nbytes;
      hdr.delete();
      hdr.push_back(1'b0);
      for (int i = 10; i >= 0; i--) hdr.push_back(x_ide ? id[18+i] : id[i]);
      if (x_ide) begin
         hdr.push_back(1'b1);
         hdr.push_back(1'b1);
         for (int i = 17; i >= 0; i--) hdr.push_back(id[i]);
         hdr.push_back(x_rtr);
         hdr.push_back(1'b0);
         hdr.push_back(1'b0);
      end else begin
         hdr.push_back(x_rtr);
         hdr.push_back(1'b0);
         hdr.push_back(1'b0);
      end
      for (int i = 3; i >= 0; i--) hdr.push_back(x_dlc[i]);
      nbytes = x_rtr ? 0 : ((x_dlc > 4'd8) ? 8 : int'(x_dlc));
      for (int i = 0; i < nbytes * 8; i++) hdr.push_back(1'($urandom_range(0, 1)));
      compute_crc();
   endtask

   task automatic send_bit(input bit b, input bit s, input bit ab);
      @(posedge clk); #1;
      bit_valid = 1'b1; bit_in = b; sof = s; abort = ab;
      @(posedge clk); #1;
      bit_valid = 1'b0; sof = 1'b0; abort = 1'b0;
      @(posedge clk);
      @(posedge clk);
   endtask

   // Runs one frame; abort_idx >= 0 aborts on that header bit.
   task automatic run_frame(input string name, input bit x_ide, input bit x_rtr,
                            input logic [3:0] x_dlc, input logic [28:0] id,
                            input logic [14:0] flip, input int abort_idx);
      int en0, done0, init0, q0, bad, exp_en;
      logic [14:0] sent;
      bit exp_err;
      build_frame(x_ide, x_rtr, x_dlc, id);
      en0 = en_total; done0 = done_total; init0 = init_total; q0 = din_q.size();
      en_at_rise = -1;
      foreach (hdr[i]) begin
         send_bit(hdr[i], i == 0, i == abort_idx);
         if (i == abort_idx) break;
      end
      sent = frame_crc ^ flip;
      if (abort_idx < 0)
         for (int i = 14; i >= 0; i--) send_bit(sent[i], 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      exp_en = (abort_idx < 0) ? hdr.size() : abort_idx;
      exp_err = (flip != 15'd0);
      bad = 0;
      for (int i = 0; i < exp_en && q0 + i < din_q.size(); i++)
         if (din_q[q0+i] != hdr[i]) bad++;
      $display("frame %s ide=%0d rtr=%0d dlc=%0d bits=%0d abort=%0d crc=%h sent=%h",
               name, x_ide, x_rtr, x_dlc, hdr.size(), abort_idx, frame_crc, sent);
      n_checks++;
      if (en_total - en0 !== exp_en) begin
         n_fail++; $display("FAIL %s crc_en count: got %0d expected %0d", name, en_total - en0, exp_en);
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL %s crc_din stream: %0d wrong bits, expected 0", name, bad);
      end
      n_checks++;
      if (init_total - init0 !== 1) begin
         n_fail++; $display("FAIL %s crc_init count: got %0d expected 1", name, init_total - init0);
      end
      n_checks++;
      if (crc_field !== 1'b0) begin
         n_fail++; $display("FAIL %s crc_field after frame: got %b expected 0", name, crc_field);
      end
      if (abort_idx >= 0) begin
         n_checks++;
         if (done_total - done0 !== 0) begin
            n_fail++; $display("FAIL %s done after abort: got %0d expected 0", name, done_total - done0);
         end
         n_checks++;
         if ({crc_ok, crc_err} !== 2'b00) begin
            n_fail++; $display("FAIL %s ok/err after abort: got %b%b expected 00", name, crc_ok, crc_err);
         end
      end else begin
         n_checks++;
         if (done_total - done0 !== 1) begin
            n_fail++; $display("FAIL %s done count: got %0d expected 1", name, done_total - done0);
         end
         n_checks++;
         if (en_at_rise - en0 !== hdr.size()) begin
            n_fail++; $display("FAIL %s bits before crc_field: got %0d expected %0d", name, en_at_rise - en0, hdr.size());
         end
         n_checks++;
         if ({crc_ok, crc_err} !== {~exp_err, exp_err}) begin
            n_fail++; $display("FAIL %s ok/err: got %b%b expected %b%b", name, crc_ok, crc_err, ~exp_err, exp_err);
         end
         n_checks++;
         if ({ide, rtr, dlc} !== {x_ide, x_rtr, x_dlc}) begin
            n_fail++; $display("FAIL %s ide/rtr/dlc: got %b/%b/%0d expected %b/%b/%0d", name, ide, rtr, dlc, x_ide, x_rtr, x_dlc);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({crc_init, crc_en, crc_din, crc_field, ide, rtr, dlc, done, crc_ok, crc_err} !== 13'd0) begin
         n_fail++; $display("FAIL reset outputs: got %b expected 0",
            {crc_init, crc_en, crc_din, crc_field, ide, rtr, dlc, done, crc_ok, crc_err});
      end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_standard();
      run_frame("std_ok", 1'b0, 1'b0, 4'd1, 29'h123, 15'd0, -1);
      run_frame("std_crc_bit7", 1'b0, 1'b0, 4'd1, 29'h123, 15'h0080, -1);
   endtask

   task automatic test_ext_remote();
      run_frame("ext_remote", 1'b1, 1'b1, 4'd8, 29'h1ABCDEF5, 15'd0, -1);
   endtask

   task automatic test_dlc12();
      run_frame("dlc12", 1'b0, 1'b0, 4'd12, 29'h7A5, 15'd0, -1);
   endtask

   task automatic test_abort();
      // Header of a DLC=2 standard frame is 19 bits; data bit 3 sits at index 22.
      run_frame("abort_data3", 1'b0, 1'b0, 4'd2, 29'h2F0, 15'd0, 22);
      run_frame("after_abort", 1'b0, 1'b0, 4'd2, 29'h2F0, 15'd0, -1);
   endtask

   task automatic test_reset_mid_frame();
      int en0;
      build_frame(1'b0, 1'b0, 4'd3, 29'h155);
      for (int i = 0; i < 4; i++) send_bit(hdr[i], i == 0, 1'b0);
      @(posedge clk); #1;
      bit_valid = 1'b1; bit_in = 1'b1;
      @(posedge clk); #1;
      bit_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({crc_init, crc_en, crc_din, crc_field, ide, rtr, dlc, done, crc_ok, crc_err} !== 13'd0) begin
         n_fail++; $display("FAIL reset_mid outputs: got %b expected 0",
            {crc_init, crc_en, crc_din, crc_field, ide, rtr, dlc, done, crc_ok, crc_err});
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      en0 = en_total;
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
      $display("frame reset_mid idle bits ignored: crc_en count %0d", en_total - en0);
      n_checks++;
      if (en_total - en0 !== 0) begin
         n_fail++; $display("FAIL reset_mid idle bits: got %0d crc_en expected 0", en_total - en0);
      end
      run_frame("after_reset", 1'b0, 1'b0, 4'd3, 29'h155, 15'd0, -1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         logic [14:0] fl;
         fl = ($urandom_range(0, 1) == 1) ? 15'(1 << $urandom_range(0, 14)) : 15'd0;
         run_frame($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), 29'($urandom), fl, -1);
      end
   endtask

   initial begin
      test_reset();
      test_standard();
      test_ext_remote();
      test_dlc12();
      test_abort();
      test_reset_mid_frame();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
